// File: rtl/stage_execute_if.sv
// Handshake and data bus between the decode/DRAM side, the execute stage and writeback.
interface stage_execute_if #(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned OP_W    = 8
);
  logic [OP_W-1:0]    operation_in;
  logic [D_WIDTH-1:0] d_in;
  logic [7:0]         cd;
  logic               crda;
  logic               cack;
  logic               ack_in;
  logic               ack;
  logic [D_WIDTH-1:0] a;
  logic [OP_W-1:0]    operation;

  modport master (
    output operation_in, d_in, cd, crda, ack_in,
    input  cack, ack, a, operation
  );

  modport slave (
    input  operation_in, d_in, cd, crda, ack_in,
    output cack, ack, a, operation
  );
endinterface

// File: rtl/stage_execute.sv
// Execute stage: computes the new cell value (inc/dec/pass/char-in) with a one-entry
// forwarding register covering cell writes not yet committed by writeback.
module stage_execute #(
  parameter int unsigned D_WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  stage_execute_if.slave   bus
);
  localparam int unsigned OPCODE_MSB = 7;
  localparam int unsigned OP_W       = OPCODE_MSB + 1;
  localparam int unsigned OP_INC     = 0;
  localparam int unsigned OP_DEC     = 1;
  localparam int unsigned OP_INCDP   = 2;
  localparam int unsigned OP_DECDP   = 3;
  localparam int unsigned OP_IN      = 5;

  logic [OP_W-1:0]    operation_q, operation_d;
  logic [D_WIDTH-1:0] a_q, a_d;
  logic               fwd_valid_q, fwd_valid_d;
  logic [D_WIDTH-1:0] src;
  logic [D_WIDTH-1:0] result;
  logic               ext_wait;
  logic               advance;

  assign ext_wait = bus.operation_in[OP_IN] && !bus.crda;
  assign advance  = bus.ack_in && !ext_wait;
  assign bus.ack  = advance;
  assign bus.cack = bus.operation_in[OP_IN] && bus.crda && bus.ack_in && !reset;

  assign bus.a         = a_q;
  assign bus.operation = operation_q;

  // Next-state: result selection and forwarding bookkeeping
  always_comb begin
    operation_d = operation_q;
    a_d         = a_q;
    fwd_valid_d = fwd_valid_q;
    src         = fwd_valid_q ? a_q : bus.d_in;
    result      = src;

    if (bus.operation_in[OP_IN]) begin
      result = D_WIDTH'(bus.cd);
    end else if (bus.operation_in[OP_INC]) begin
      result = src + D_WIDTH'(1);
    end else if (bus.operation_in[OP_DEC]) begin
      result = src - D_WIDTH'(1);
    end

    if (advance) begin
      operation_d = bus.operation_in;
      a_d         = result;
      if (bus.operation_in[OP_INC] || bus.operation_in[OP_DEC] || bus.operation_in[OP_IN]) begin
        fwd_valid_d = 1'b1;
      end else if (bus.operation_in[OP_INCDP] || bus.operation_in[OP_DECDP]) begin
        fwd_valid_d = 1'b0;
      end
    end else if (bus.ack_in) begin
      // Waiting on the character device: send a bubble, keep the cell value
      operation_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      operation_q <= '0;
      a_q         <= '0;
      fwd_valid_q <= 1'b0;
    end else begin
      operation_q <= operation_d;
      a_q         <= a_d;
      fwd_valid_q <= fwd_valid_d;
    end
  end
endmodule

// File: tb/tb_stage_execute.sv
// Directed bench for stage_execute with a reference model feeding an expected-result queue.
module tb_stage_execute;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 8;

  localparam logic [OW-1:0] NOP   = 8'h00;
  localparam logic [OW-1:0] INC   = 8'h01;
  localparam logic [OW-1:0] DEC   = 8'h02;
  localparam logic [OW-1:0] INCDP = 8'h04;
  localparam logic [OW-1:0] DECDP = 8'h08;
  localparam logic [OW-1:0] OUT   = 8'h10;
  localparam logic [OW-1:0] IN    = 8'h20;
  localparam logic [OW-1:0] JZ    = 8'h40;

  typedef struct packed {
    logic [OW-1:0] op;
    logic [DW-1:0] a;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  exp_t          sb_q[$];
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_a;
  logic          m_fwd;

  stage_execute_if #(.D_WIDTH(DW), .OP_W(OW)) bus ();

  stage_execute #(.D_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, model, then check registers.
  // exp_a < 0 means no extra directed check on a.
  task automatic step(input logic rst, input logic [OW-1:0] op, input logic [DW-1:0] d,
                      input logic [7:0] cdv, input logic crdav, input logic ackin,
                      input int exp_a);
    logic          ew;
    logic [DW-1:0] src;
    logic [DW-1:0] res;
    exp_t          e;
    exp_t          got;
    @(negedge clk);
    reset           = rst;
    bus.operation_in = op;
    bus.d_in        = d;
    bus.cd          = cdv;
    bus.crda        = crdav;
    bus.ack_in      = ackin;
    #1;
    ew = op[5] && !crdav;
    check("ack", 32'(bus.ack), 32'(ackin && !ew));
    check("cack", 32'(bus.cack), 32'(op[5] && crdav && ackin && !rst));

    src = m_fwd ? m_a : d;
    case (op)
      INC:     res = src + 8'd1;
      DEC:     res = src - 8'd1;
      IN:      res = cdv;
      default: res = src;
    endcase
    if (rst) begin
      m_op = '0; m_a = '0; m_fwd = 1'b0;
    end else if (ackin && !ew) begin
      m_op = op;
      m_a  = res;
      if (op == INC || op == DEC || op == IN) m_fwd = 1'b1;
      else if (op == INCDP || op == DECDP) m_fwd = 1'b0;
    end else if (ackin) begin
      m_op = '0;
    end
    e.op = m_op;
    e.a  = m_a;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("operation", 32'(bus.operation), 32'(got.op));
    check("a", 32'(bus.a), 32'(got.a));
    if (exp_a >= 0) check("a_directed", 32'(bus.a), 32'(exp_a));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_op  = '0;
    m_a   = '0;
    m_fwd = 1'b0;
    reset = 1'b1;
    bus.operation_in = '0;
    bus.d_in   = '0;
    bus.cd     = '0;
    bus.crda   = 1'b0;
    bus.ack_in = 1'b0;

    // Reset held with activity on the inputs
    step(1'b1, IN,  8'h33, 8'h55, 1'b1, 1'b1, 0);
    step(1'b1, INC, 8'h33, 8'h55, 1'b1, 1'b1, 0);

    // Forwarding against stale DRAM data
    step(1'b0, INC, 8'h05, 8'h00, 1'b0, 1'b1, 8'h06);
    step(1'b0, INC, 8'h05, 8'h00, 1'b0, 1'b1, 8'h07);
    step(1'b0, DEC, 8'h05, 8'h00, 1'b0, 1'b1, 8'h06);

    // Pointer move invalidates forwarding
    step(1'b0, INCDP, 8'h00, 8'h00, 1'b0, 1'b1, -1);
    step(1'b0, INC,   8'h10, 8'h00, 1'b0, 1'b1, 8'h11);
    step(1'b0, INCDP, 8'h00, 8'h00, 1'b0, 1'b1, -1);
    step(1'b0, INC,   8'h20, 8'h00, 1'b0, 1'b1, 8'h21);

    // Wrap both ways
    step(1'b0, DECDP, 8'h00, 8'h00, 1'b0, 1'b1, -1);
    step(1'b0, INC,   8'hFF, 8'h00, 1'b0, 1'b1, 8'h00);
    step(1'b0, INCDP, 8'h00, 8'h00, 1'b0, 1'b1, -1);
    step(1'b0, DEC,   8'h00, 8'h00, 1'b0, 1'b1, 8'hFF);

    // Char-in stall then accept, then forwarded increment
    for (int i = 0; i < 3; i++) step(1'b0, IN, 8'h00, 8'h41, 1'b0, 1'b1, 8'hFF);
    step(1'b0, IN,  8'h00, 8'h41, 1'b1, 1'b1, 8'h41);
    step(1'b0, INC, 8'h00, 8'h00, 1'b0, 1'b1, 8'h42);

    // Downstream stall holds everything, no consume
    step(1'b0, IN, 8'h00, 8'h77, 1'b1, 1'b0, 8'h42);
    step(1'b0, IN, 8'h00, 8'h77, 1'b1, 1'b0, 8'h42);

    // OUT, loop op and bubble keep forwarded value
    step(1'b0, OUT, 8'h99, 8'h00, 1'b0, 1'b1, 8'h42);
    step(1'b0, JZ,  8'h99, 8'h00, 1'b0, 1'b1, 8'h42);
    step(1'b0, NOP, 8'h99, 8'h00, 1'b0, 1'b1, 8'h42);
    step(1'b0, INC, 8'h99, 8'h00, 1'b0, 1'b1, 8'h43);

    // Char-in with byte already available: no stall
    step(1'b0, IN,  8'h00, 8'h7F, 1'b1, 1'b1, 8'h7F);
    step(1'b0, DEC, 8'h00, 8'h00, 1'b0, 1'b1, 8'h7E);

    // Reset during a stall
    step(1'b0, IN, 8'h00, 8'h12, 1'b0, 1'b1, 8'h7E);
    step(1'b1, IN, 8'h00, 8'h12, 1'b1, 1'b1, 0);
    step(1'b0, INC, 8'h30, 8'h00, 1'b0, 1'b1, 8'h31);

    // Random tail against the model
    for (int i = 0; i < 40; i++) begin
      logic [OW-1:0] op;
      case ($urandom_range(0, 7))
        0: op = INC;   1: op = DEC;   2: op = INCDP; 3: op = DECDP;
        4: op = OUT;   5: op = IN;    6: op = JZ;    default: op = NOP;
      endcase
      step(1'b0, op, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stage_execute.md
# stage_execute

Pipeline stage directly upstream of the writeback stage in the bfcpu2 core. Takes the decoded one-hot operation and the current cell value read from DRAM, computes the new cell value (increment, decrement, pass-through, or a byte read from the character device), and presents it as `a` with the operation to writeback. Holds a one-entry forwarding register so back-to-back cell-modifying ops do not see stale DRAM data before writeback has committed. Stalls only on `OP_IN` with no input byte available.

## Interface
- `D_WIDTH`, 8, cell/accumulator width; arithmetic wraps mod 2^D_WIDTH.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `operation_in`  in  `OPCODE_MSB+1`  one-hot opcode from upstream (all-zero = bubble).
- `d_in`  in  D_WIDTH  DRAM value of cell at current dp, valid whenever `operation_in` is non-zero.
- `cd`  in  8  character-device input byte.
- `crda`  in  1  input byte available on `cd`.
- `cack`  out  1  consume strobe for `cd`; one cycle per byte taken.
- `ack_in`  in  1  downstream (writeback) accepts this cycle.
- `ack`  out  1  upstream may advance.
- `a`  out reg  D_WIDTH  result value to writeback.
- `operation`  out reg  `OPCODE_MSB+1`  opcode to writeback.

## Operation
- Source value: `src = fwd_valid ? a : d_in`.
- Result by opcode (one-hot, bits from Constants.v):
  - `OP_INC`: src + 1; `OP_DEC`: src - 1 (wrap 0xFF+1=0x00, 0x00-1=0xFF for D_WIDTH=8).
  - `OP_IN`: `cd` zero-extended (or truncated) to D_WIDTH.
  - `OP_OUT` and all other ops: src (unchanged).
- `ext_wait = operation_in[OP_IN] && !crda`.
- `ack = ack_in && !ext_wait` (combinational).
- `cack = operation_in[OP_IN] && crda && ack_in && !reset`; never asserted for other ops or while `ack_in`=0.
- Register update (posedge clk, in priority order):
  - reset: `operation`<=0, `a`<=0, `fwd_valid`<=0.
  - `ack_in && !ext_wait`: `operation`<=`operation_in`; `a`<=result; fwd_valid updated as below.
  - `ack_in && ext_wait`: `operation`<=0 (bubble); `a`, `fwd_valid` hold.
  - `!ack_in`: all state holds.
- fwd_valid on an advancing op: set to 1 for `OP_INC`/`OP_DEC`/`OP_IN`; cleared for `OP_INCDP`/`OP_DECDP`; unchanged for `OP_OUT`, loop ops and bubbles (all-zero `operation_in`).
- Bubbles advance normally: `operation`<=0, `a` loaded with src (harmless; writeback ignores it), fwd_valid unchanged.

## Timing
- Latency 1 cycle: op accepted at edge N appears on `operation`/`a` after edge N.
- Throughput 1 op/cycle except `OP_IN` with `crda`=0, which stalls until `crda`=1 and inserts bubbles downstream meanwhile.
- `cd`/`crda` sampled in the same cycle `cack` is asserted; byte captured into `a` at that edge.
- Simultaneous `OP_IN` arrival and `crda` rising: no stall; accepted same cycle.
- Forwarding covers any distance between modifying ops as long as no dp-moving op intervenes.
- Reset mid-stall: next cycle `operation`=0, `a`=0, `fwd_valid`=0, `cack`=0 during reset; pending byte not consumed.

## Test plan
- Reset: assert reset 2 cycles with ops/`crda` active -> `operation`=0, `a`=0, `cack`=0 throughout.
- Forwarding: `d_in`=0x05 held stale, feed INC, INC, DEC -> `a` = 0x06, 0x07, 0x06 on successive cycles.
- Pointer invalidation: INC (`d_in`=0x10) -> a=0x11; INCDP; INC with `d_in`=0x20 -> a=0x21 (not 0x12).
- Wrap: `d_in`=0xFF, INC -> 0x00; after INCDP, `d_in`=0x00, DEC -> 0xFF.
- IN stall: `OP_IN`, `crda`=0 for 3 cycles -> `ack`=0, `operation`=0 each cycle, `cack`=0; then `crda`=1, `cd`=0x41 -> `cack`=1 one cycle, `a`=0x41, `operation`=OP_IN; next INC -> 0x42.
- Downstream stall: `ack_in`=0 with `OP_IN` and `crda`=1 -> `ack`=0, `cack`=0, `operation`/`a` hold.
